// File: rtl/pe_result_drain.sv
// pe_result_drain
//   Downstream stage of the 2x4 multiply PE array. Waits for every PE to
//   report done, then copies the packed result bus into a local buffer and
//   pulses tempc_ack. It then streams the eight result words over a
//   valid/ready port to the result memory writer. No new tile is accepted
//   until the buffer has fully drained and the done flags have dropped.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     pedone[NPE]          per-PE done flags
//     tempc[NPE*RES_W]     packed PE results, word i = tempc[RES_W*i +: RES_W]
//     tempc_ack            one-cycle result-accepted pulse
//     out_valid/out_ready  beat handshake toward the memory writer
//     out_data, out_idx    current word and its index (0..7)
//     out_last             high on the beat with out_idx == 7
//     out_tile             sequence number of the tile being drained
//     busy                 high whenever the block is not idle
//     err_sticky           protocol monitor flag (only with DRAIN_BEAT_CHK_EN)
//
//   Build option: define DRAIN_BEAT_CHK_EN to add the err_sticky monitor.
module pe_result_drain #(
    parameter int unsigned NPE    = 8,
    parameter int unsigned RES_W  = 128,
    parameter int unsigned TILE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPE-1:0]       pedone,
    input  logic [NPE*RES_W-1:0] tempc,
    output logic                 tempc_ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_W-1:0]     out_data,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic [TILE_W-1:0]    out_tile,
    output logic                 busy
`ifdef DRAIN_BEAT_CHK_EN
    ,
    output logic                 err_sticky
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CAPT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [RES_W-1:0]  res_buf_q [NPE];
    logic [RES_W-1:0]  res_buf_d [NPE];
    logic              tempc_ack_q, tempc_ack_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_idx_q,   out_idx_d;
    logic [TILE_W-1:0] out_tile_q,  out_tile_d;

    logic all_done;
    logic xfer;

    assign all_done = &pedone;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        res_buf_d   = res_buf_q;
        tempc_ack_d = tempc_ack_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_tile_d  = out_tile_q;
        case (state_q)
            ST_IDLE: begin
                if (all_done) begin
                    for (int unsigned i = 0; i < NPE; i++) begin
                        res_buf_d[i] = tempc[RES_W*i +: RES_W];
                    end
                    tempc_ack_d = 1'b1;
                    state_d     = ST_CAPT;
                end
            end
            ST_CAPT: begin
                tempc_ack_d = 1'b0;
                out_valid_d = 1'b1;
                out_idx_d   = '0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (xfer) begin
                    if (out_idx_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_tile_d  = out_tile_q + TILE_W'(1);
                        // Done flags still high here belong to the tile just
                        // drained; wait for them to drop before re-arming.
                        state_d     = all_done ? ST_HOLD : ST_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (!all_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            res_buf_q   <= '{default: '0};
            tempc_ack_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_tile_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_buf_q   <= res_buf_d;
            tempc_ack_q <= tempc_ack_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_tile_q  <= out_tile_d;
        end
    end

    assign tempc_ack = tempc_ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_buf_q[out_idx_q];
    assign out_idx   = out_idx_q;
    assign out_last  = out_valid_q && (out_idx_q == 3'd7);
    assign out_tile  = out_tile_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef DRAIN_BEAT_CHK_EN
    // Snapshot of a stalled beat; the following cycle must present the
    // same beat with valid still high.
    logic             stall_q,     stall_d;
    logic [RES_W-1:0] hold_data_q, hold_data_d;
    logic [2:0]       hold_idx_q,  hold_idx_d;
    logic             err_q,       err_d;

    always_comb begin
        stall_d     = (state_q == ST_DRAIN) && out_valid_q && !out_ready;
        hold_data_d = out_data;
        hold_idx_d  = out_idx_q;
        err_d       = err_q;
        if (stall_q && (!out_valid_q || (out_data != hold_data_q) ||
                        (out_idx_q != hold_idx_q))) begin
            err_d = 1'b1;
        end
        if ((state_q == ST_CAPT) && !all_done) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q     <= 1'b0;
            hold_data_q <= '0;
            hold_idx_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            hold_data_q <= hold_data_d;
            hold_idx_q  <= hold_idx_d;
            err_q       <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain
//   Self-checking bench for pe_result_drain: a scripted vector table for the
//   basic drain and back-pressure case, directed sequences for partial done,
//   stale done, buffer isolation and reset mid-drain, then randomized traffic
//   checked every cycle against a queue-based reference model.
module tb_pe_result_drain;

    logic          clk;
    logic          rst;
    logic [7:0]    pedone;
    logic [1023:0] tempc;
    logic          tempc_ack;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [2:0]    out_idx;
    logic          out_last;
    logic [7:0]    out_tile;
    logic          busy;
`ifdef DRAIN_BEAT_CHK_EN
    logic          err_sticky;
`endif

    pe_result_drain #(.NPE(8), .RES_W(128), .TILE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pedone    (pedone),
        .tempc     (tempc),
        .tempc_ack (tempc_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_tile  (out_tile),
        .busy      (busy)
`ifdef DRAIN_BEAT_CHK_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt  = 0;
    int beat_cnt = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference model: a tile is a queue of pending words; an accepted tile
    // spends one cycle acknowledging before its words become visible.
    logic [127:0]  m_q[$];
    logic [1023:0] m_cap;
    bit            m_ack;
    bit            m_stale;
    logic [7:0]    m_tile;

    function automatic void model_update();
        if (rst) begin
            m_q.delete();
            m_ack   = 0;
            m_stale = 0;
            m_tile  = 0;
        end else if (m_q.size() > 0) begin
            if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_tile  = m_tile + 8'd1;
                    m_stale = (pedone == 8'hFF);
                end
            end
        end else if (m_ack) begin
            m_ack = 0;
            for (int i = 0; i < 8; i++) m_q.push_back(m_cap[128*i +: 128]);
        end else if (m_stale) begin
            if (pedone != 8'hFF) m_stale = 0;
        end else if (pedone == 8'hFF) begin
            m_cap = tempc;
            m_ack = 1;
        end
    endfunction

    function automatic void model_check();
        bit         v;
        logic [2:0] idx;
        v   = (m_q.size() > 0);
        idx = v ? 3'(8 - m_q.size()) : 3'd0;
        chk("m_valid", 128'(out_valid), 128'(v));
        chk("m_ack",   128'(tempc_ack), 128'(m_ack));
        chk("m_idx",   128'(out_idx),   128'(idx));
        chk("m_last",  128'(out_last),  128'(m_q.size() == 1));
        chk("m_busy",  128'(busy),      128'(m_ack || v || m_stale));
        chk("m_tile",  128'(out_tile),  128'(m_tile));
        if (v) chk("m_data", out_data, m_q[0]);
    endfunction

    task automatic step(input bit use_model);
        @(posedge clk);
        if (out_valid && out_ready && !rst) beat_cnt++;
        model_update();
        #1;
        if (tempc_ack) ack_cnt++;
        if (use_model) model_check();
    endtask

    function automatic void set_pattern(input logic [127:0] base);
        for (int i = 0; i < 8; i++) tempc[128*i +: 128] = base + 128'(i);
    endfunction

    typedef struct {
        bit         rst;
        logic [7:0] pedone;
        bit         ready;
        bit         ack;
        bit         valid;
        logic [2:0] idx;
        bit         busy;
        logic [7:0] tile;
    } vec_t;

    vec_t vecs[18];

    initial begin
        rst       = 1'b1;
        pedone    = 8'h00;
        out_ready = 1'b1;
        set_pattern(128'h1000);
        step(0);

        // Basic drain with a 5-cycle stall at idx 3.
        vecs[0]  = '{1, 8'h00, 1, 0, 0, 3'd0, 0, 8'd0};
        vecs[1]  = '{0, 8'h7F, 1, 0, 0, 3'd0, 0, 8'd0};
        vecs[2]  = '{0, 8'hFF, 1, 1, 0, 3'd0, 1, 8'd0};
        vecs[3]  = '{0, 8'hFF, 1, 0, 1, 3'd0, 1, 8'd0};
        vecs[4]  = '{0, 8'h00, 1, 0, 1, 3'd1, 1, 8'd0};
        vecs[5]  = '{0, 8'h00, 1, 0, 1, 3'd2, 1, 8'd0};
        vecs[6]  = '{0, 8'h00, 1, 0, 1, 3'd3, 1, 8'd0};
        vecs[7]  = '{0, 8'h00, 0, 0, 1, 3'd3, 1, 8'd0};
        vecs[8]  = '{0, 8'h00, 0, 0, 1, 3'd3, 1, 8'd0};
        vecs[9]  = '{0, 8'h00, 0, 0, 1, 3'd3, 1, 8'd0};
        vecs[10] = '{0, 8'h00, 0, 0, 1, 3'd3, 1, 8'd0};
        vecs[11] = '{0, 8'h00, 0, 0, 1, 3'd3, 1, 8'd0};
        vecs[12] = '{0, 8'h00, 1, 0, 1, 3'd4, 1, 8'd0};
        vecs[13] = '{0, 8'h00, 1, 0, 1, 3'd5, 1, 8'd0};
        vecs[14] = '{0, 8'h00, 1, 0, 1, 3'd6, 1, 8'd0};
        vecs[15] = '{0, 8'h00, 1, 0, 1, 3'd7, 1, 8'd0};
        vecs[16] = '{0, 8'h00, 1, 0, 0, 3'd0, 0, 8'd1};
        vecs[17] = '{0, 8'h00, 1, 0, 0, 3'd0, 0, 8'd1};

        for (int unsigned k = 0; k < 18; k++) begin
            rst       = vecs[k].rst;
            pedone    = vecs[k].pedone;
            out_ready = vecs[k].ready;
            step(0);
            chk($sformatf("v%0d_ack", k),   128'(tempc_ack), 128'(vecs[k].ack));
            chk($sformatf("v%0d_valid", k), 128'(out_valid), 128'(vecs[k].valid));
            chk($sformatf("v%0d_idx", k),   128'(out_idx),   128'(vecs[k].idx));
            chk($sformatf("v%0d_last", k),  128'(out_last),
                128'(vecs[k].valid && vecs[k].idx == 3'd7));
            chk($sformatf("v%0d_busy", k),  128'(busy),      128'(vecs[k].busy));
            chk($sformatf("v%0d_tile", k),  128'(out_tile),  128'(vecs[k].tile));
            if (vecs[k].valid)
                chk($sformatf("v%0d_data", k), out_data, 128'h1000 + 128'(vecs[k].idx));
        end
`ifdef DRAIN_BEAT_CHK_EN
        chk("err_after_stall", 128'(err_sticky), 128'(0));
`endif

        // Partial done is ignored.
        ack_cnt = 0;
        pedone  = 8'h7F;
        set_pattern(128'h1100);
        for (int i = 0; i < 20; i++) step(1);
        chk("partial_acks", 128'(ack_cnt), 128'(0));

        // Full done, then held high through the drain: exactly one capture.
        pedone = 8'hFF;
        step(1);
        chk("partial_then_full_ack", 128'(tempc_ack), 128'(1));
        for (int i = 0; i < 14; i++) step(1);
        chk("stale_acks", 128'(ack_cnt), 128'(1));
        chk("stale_hold_busy", 128'(busy), 128'(1));

        // Drop and re-raise done; tempc overwritten during the drain.
        ack_cnt = 0;
        set_pattern(128'h2000);
        pedone = 8'h00;
        step(1);
        step(1);
        pedone = 8'hFF;
        step(1);
        step(1);
        tempc = '1;
        for (int i = 0; i < 12; i++) step(1);
        chk("rearm_acks", 128'(ack_cnt), 128'(1));

        // Reset at idx 4, then a clean tile.
        pedone = 8'h00;
        step(1);
        set_pattern(128'h3000);
        pedone = 8'hFF;
        for (int i = 0; i < 20 && !(out_valid && out_idx == 3'd4); i++) step(1);
        chk("reach_idx4", 128'(out_valid && out_idx == 3'd4), 128'(1));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_idx",   128'(out_idx),   128'(0));
        chk("rst_tile",  128'(out_tile),  128'(0));
        chk("rst_ack",   128'(tempc_ack), 128'(0));
        ack_cnt  = 0;
        beat_cnt = 0;
        for (int i = 0; i < 12; i++) step(1);
        chk("post_rst_acks",  128'(ack_cnt),  128'(1));
        chk("post_rst_beats", 128'(beat_cnt), 128'(8));
        chk("post_rst_tile",  128'(out_tile), 128'(1));

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            pedone    = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0)
                for (int w = 0; w < 32; w++) tempc[32*w +: 32] = $urandom;
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
